// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and the bus addresses
// that the address decoder also uses.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DATA_BITS = 8;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_4000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_4004;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous clear.
// bit_end marks the last cycle of a bit; near_end marks the cycle before it.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end,
  output logic near_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end  = (cnt == LAST);
  assign near_end = (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter, 8N1 framing, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       near_end;
`ifdef UART_TX_PARITY_EN
  logic       parity;
`endif

  // Counter is held at zero while idle so every frame starts on a fresh bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .bit_end (bit_end),
    .near_end(near_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      shift   <= '0;
      bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (wr_en) begin
            shift <= wr_data;
`ifdef UART_TX_PARITY_EN
            parity <= ^wr_data;
`endif
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          // tx is registered, so the next bit is loaded from shift[1] before shifting.
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (near_end) tx_done <= 1'b1;
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit: frame table plus hand-written
// sequences for reset, writes while busy, back-to-back frames and mid-frame reset.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // bit i = i-th transmitted bit (start first)
  } vec_t;

  vec_t vecs[4];

  uart_tx #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .tx     (tx),
    .busy   (busy),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Drives a one-cycle write starting now; returns just after the sampling edge.
  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Checks ncycles of the frame from the cycle after the accepting edge; when the
  // whole frame is checked, also checks the first idle cycle after it.
  task automatic check_frame(input logic [10:0] frame, input int ncycles);
    for (int k = 0; k < ncycles; k++) begin
      @(negedge clk);
      check("tx_bit", tx, frame[k / CPB]);
      check("busy_in_frame", busy, 1'b1);
      check("tx_done_pulse", tx_done, (k == NB * CPB - 1) ? 1'b1 : 1'b0);
    end
    if (ncycles == NB * CPB) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_tx_done", tx_done, 1'b0);
    end
  endtask

  task automatic check_idle(input int ncycles);
    for (int k = 0; k < ncycles; k++) begin
      @(negedge clk);
      check("quiet_tx", tx, 1'b1);
      check("quiet_busy", busy, 1'b0);
      check("quiet_tx_done", tx_done, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{data: 8'h07, frame: 11'h60E};
    vecs[1] = '{data: 8'h03, frame: 11'h406};
    vecs[2] = '{data: 8'hA5, frame: 11'h54A};
    vecs[3] = '{data: 8'hFF, frame: 11'h5FE};
`else
    vecs[0] = '{data: 8'hA5, frame: 11'h34A};
    vecs[1] = '{data: 8'h00, frame: 11'h200};
    vecs[2] = '{data: 8'hFF, frame: 11'h3FE};
    vecs[3] = '{data: 8'h55, frame: 11'h2AA};
`endif

    // Reset held with a pending write: line stays idle, nothing starts on release.
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_tx_done", tx_done, 1'b0);
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    check_idle(20);

    // Table of single frames.
    foreach (vecs[i]) begin
      @(negedge clk);
      write_byte(vecs[i].data);
      check_frame(vecs[i].frame, NB * CPB);
      check_idle(3);
    end

    // Writes at cycle 40 and on the tx_done cycle are dropped.
    @(negedge clk);
    write_byte(8'h55);
    fork
      check_frame(mk_frame(8'h55), NB * CPB);
      begin
        repeat (39) @(posedge clk);
        #1;
        write_byte(8'h0F);
        repeat (NB * CPB - 42) @(posedge clk);
        #1;
        write_byte(8'h0F);
      end
    join
    check_idle(40);

    // Back-to-back: second write on the first idle cycle.
    @(negedge clk);
    write_byte(8'h00);
    check_frame(mk_frame(8'h00), NB * CPB);
    write_byte(8'hFF);
    check_frame(mk_frame(8'hFF), NB * CPB);
    check_idle(3);

    // Reset at cycle 70 abandons the frame; the next frame is clean.
    @(negedge clk);
    write_byte(8'h3C);
    check_frame(mk_frame(8'h3C), 70);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    check_idle(5);
    write_byte(8'hC3);
    check_frame(mk_frame(8'hC3), NB * CPB);
    check_idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
